// File: rtl/frame_pkg.sv
// Shared constants, screen encodings and pipeline types for the frame painter.
package frame_pkg;

    localparam int H_RES_DEFAULT = 160;
    localparam int V_RES_DEFAULT = 120;
    localparam int COLOUR_W      = 3;

    typedef enum logic [1:0] {
        SCR_TITLE = 2'b00,
        SCR_GAME  = 2'b01,
        SCR_WIN   = 2'b10,
        SCR_LOSE  = 2'b11
    } screen_t;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        FLUSH,
        DONE_ST
    } state_t;

    // One in-flight pixel waiting for ROM data.
    typedef struct packed {
        logic       valid;
        logic [7:0] x;
        logic [6:0] y;
        logic       in_sprite;
    } pix_t;

endpackage

// File: rtl/raster_xy.sv
// Raster x/y counter: synchronous clear, advance on enable, wraps at the frame end.
module raster_xy
    import frame_pkg::*;
#(
    parameter int H_RES = H_RES_DEFAULT,
    parameter int V_RES = V_RES_DEFAULT,
    parameter int XW    = 8,
    parameter int YW    = 7
) (
    input  logic          CLOCK,
    input  logic          RESETN,
    input  logic          clear,
    input  logic          enable,
    output logic [XW-1:0] x,
    output logic [YW-1:0] y,
    output logic          last
);

    logic row_end;

    assign row_end = (x == XW'(H_RES - 1));
    assign last    = row_end && (y == YW'(V_RES - 1));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (enable) begin
            if (row_end) begin
                x <= '0;
                y <= last ? '0 : y + YW'(1);
            end else begin
                x <= x + XW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_painter.sv
// Paints one full frame into the VGA adapter per trigger, compositing the car sprite on gameplay.
module frame_painter
    import frame_pkg::*;
#(
    parameter int                  H_RES       = H_RES_DEFAULT,
    parameter int                  V_RES       = V_RES_DEFAULT,
    parameter int                  ROM_LATENCY = 1,
    parameter int                  SPRITE_W    = 8,
    parameter int                  SPRITE_H    = 12,
    parameter logic [COLOUR_W-1:0] TRANSPARENT = 3'b101
) (
    input  logic                CLOCK,
    input  logic                RESETN,
    input  logic [1:0]          SCREEN,
    input  logic                START,
    input  logic [7:0]          CAR_X,
    input  logic [6:0]          CAR_Y,
    input  logic [COLOUR_W-1:0] BG_COLOUR,
    input  logic [COLOUR_W-1:0] SPR_COLOUR,
    output logic [14:0]         ROM_ADDR,
    output logic [6:0]          SPR_ADDR,
    output logic [7:0]          VGA_X,
    output logic [6:0]          VGA_Y,
    output logic [COLOUR_W-1:0] VGA_COLOUR,
    output logic                VGA_PLOT,
    output logic                BUSY,
    output logic                DONE
);

    localparam int FW = $clog2(ROM_LATENCY + 1) + 1;

    state_t        state;
    screen_t       scr_q;
    logic          pending;
    logic [7:0]    car_x_q;
    logic [6:0]    car_y_q;
    logic [FW-1:0] flush_cnt;

    logic [7:0] x;
    logic [6:0] y;
    logic       last;
    logic       trigger, abort, clear, enable;
    logic [7:0] dx, dy;
    logic       in_sprite;
    pix_t       pipe [ROM_LATENCY];

    assign trigger = (state == IDLE) && (pending || START || (screen_t'(SCREEN) != scr_q));
    assign abort   = ((state == SWEEP) || (state == FLUSH)) && (screen_t'(SCREEN) != scr_q);
    assign clear   = trigger || abort;
    assign enable  = (state == SWEEP);

    raster_xy #(.H_RES(H_RES), .V_RES(V_RES)) u_raster (
        .CLOCK (CLOCK),
        .RESETN(RESETN),
        .clear (clear),
        .enable(enable),
        .x     (x),
        .y     (y),
        .last  (last)
    );

    // Unsigned 8-bit offsets: positions left of or above the car wrap to large values and fall outside.
    assign dx        = x - car_x_q;
    assign dy        = {1'b0, y} - {1'b0, car_y_q};
    assign in_sprite = (scr_q == SCR_GAME) && (dx < 8'(SPRITE_W)) && (dy < 8'(SPRITE_H));
    assign SPR_ADDR  = 7'(dy * 8'(SPRITE_W) + dx);
    assign ROM_ADDR  = {y, x};

    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= IDLE;
            scr_q     <= SCR_TITLE;
            pending   <= 1'b1;
            car_x_q   <= '0;
            car_y_q   <= '0;
            flush_cnt <= '0;
            BUSY      <= 1'b0;
            DONE      <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: if (trigger) begin
                    scr_q   <= screen_t'(SCREEN);
                    car_x_q <= CAR_X;
                    car_y_q <= CAR_Y;
                    pending <= 1'b0;
                    BUSY    <= 1'b1;
                    state   <= SWEEP;
                end
                SWEEP: if (abort) begin
                    scr_q <= screen_t'(SCREEN);
                end else if (last) begin
                    flush_cnt <= '0;
                    state     <= FLUSH;
                end
                FLUSH: if (abort) begin
                    scr_q <= screen_t'(SCREEN);
                    state <= SWEEP;
                end else if (flush_cnt == FW'(ROM_LATENCY)) begin
                    BUSY  <= 1'b0;
                    DONE  <= 1'b1;
                    state <= DONE_ST;
                end else begin
                    flush_cnt <= flush_cnt + FW'(1);
                end
                default: state <= IDLE;
            endcase
            if (START && (state != IDLE))
                pending <= 1'b1;
        end
    end

    // Pixel tags travel beside the ROM read; an abort squashes every valid bit at once.
    // NOTE: the tag shift register is a handful of flops, so it is reset like ordinary state; a true RAM would not be.
    always_ff @(posedge CLOCK or negedge RESETN) begin
        if (!RESETN) begin
            for (int i = 0; i < ROM_LATENCY; i++)
                pipe[i] <= '0;
            VGA_X      <= '0;
            VGA_Y      <= '0;
            VGA_COLOUR <= '0;
            VGA_PLOT   <= 1'b0;
        end else begin
            pipe[0] <= '{valid: enable && !abort, x: x, y: y, in_sprite: in_sprite};
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe[i]       <= pipe[i-1];
                pipe[i].valid <= pipe[i-1].valid && !abort;
            end
            VGA_PLOT   <= pipe[ROM_LATENCY-1].valid && !abort;
            VGA_X      <= pipe[ROM_LATENCY-1].x;
            VGA_Y      <= pipe[ROM_LATENCY-1].y;
            VGA_COLOUR <= (pipe[ROM_LATENCY-1].in_sprite && (SPR_COLOUR != TRANSPARENT))
                          ? SPR_COLOUR : BG_COLOUR;
        end
    end

endmodule

// File: tb/tb_frame_painter.sv
// Directed bench for frame_painter with registered ROM models and a plot-capturing frame buffer.
module tb_frame_painter;

    logic        CLOCK = 1'b0;
    logic        RESETN;
    logic [1:0]  SCREEN;
    logic        START;
    logic [7:0]  CAR_X;
    logic [6:0]  CAR_Y;
    logic [2:0]  BG_COLOUR;
    logic [2:0]  SPR_COLOUR;
    logic [14:0] ROM_ADDR;
    logic [6:0]  SPR_ADDR;
    logic [7:0]  VGA_X;
    logic [6:0]  VGA_Y;
    logic [2:0]  VGA_COLOUR;
    logic        VGA_PLOT;
    logic        BUSY;
    logic        DONE;

    int total = 0;
    int bad   = 0;
    int plot_cnt = 0;
    int done_cnt = 0;
    logic [2:0] fb [0:19199];
    logic [2:0] bg_q  = 3'b000;
    logic [2:0] spr_q = 3'b000;

    frame_painter dut (
        .CLOCK     (CLOCK),
        .RESETN    (RESETN),
        .SCREEN    (SCREEN),
        .START     (START),
        .CAR_X     (CAR_X),
        .CAR_Y     (CAR_Y),
        .BG_COLOUR (BG_COLOUR),
        .SPR_COLOUR(SPR_COLOUR),
        .ROM_ADDR  (ROM_ADDR),
        .SPR_ADDR  (SPR_ADDR),
        .VGA_X     (VGA_X),
        .VGA_Y     (VGA_Y),
        .VGA_COLOUR(VGA_COLOUR),
        .VGA_PLOT  (VGA_PLOT),
        .BUSY      (BUSY),
        .DONE      (DONE)
    );

    always #5 CLOCK = ~CLOCK;

    // One-cycle ROMs: background = {x[0], screen}, sprite = see-through in column 0, else 010.
    always @(posedge CLOCK) begin
        bg_q  <= {ROM_ADDR[0], SCREEN};
        spr_q <= (SPR_ADDR[2:0] == 3'd0) ? 3'b101 : 3'b010;
    end
    assign BG_COLOUR  = bg_q;
    assign SPR_COLOUR = spr_q;

    always @(posedge CLOCK) begin
        #1;
        if (VGA_PLOT === 1'b1) begin
            if (int'(VGA_Y) * 160 + int'(VGA_X) < 19200)
                fb[int'(VGA_Y) * 160 + int'(VGA_X)] = VGA_COLOUR;
            plot_cnt++;
        end
        if (DONE === 1'b1)
            done_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    function automatic logic [2:0] exp_game(int x, int y, int cx, int cy);
        int dx = x - cx;
        int dy = y - cy;
        if (dx > 0 && dx < 8 && dy >= 0 && dy < 12)
            return 3'b010;
        return (x % 2 == 1) ? 3'b101 : 3'b001;
    endfunction

    function automatic logic [2:0] fb_at(int x, int y);
        return fb[y * 160 + x];
    endfunction

    initial begin
        int n;
        int base;
        int base2;
        int done0;
        int mism;
        logic busy_seen;

        RESETN = 1'b0; SCREEN = 2'b00; START = 1'b0; CAR_X = 8'd0; CAR_Y = 7'd0;
        repeat (3) tick();
        check("reset_flags", {VGA_PLOT, BUSY, DONE}, 0);
        check("reset_rom_addr", ROM_ADDR, 0);
        check("reset_vga_xyc", {VGA_X, VGA_Y, VGA_COLOUR}, 0);

        // Title frame after reset release, no START needed.
        RESETN = 1'b1;
        tick(); n = 1;
        check("t1_busy_e1", BUSY, 1);
        check("t1_addr_e1", ROM_ADDR, 0);
        check("t1_plot_e1", VGA_PLOT, 0);
        tick(); n = 2;
        check("t1_addr_e2", ROM_ADDR, 1);
        check("t1_plot_e2", VGA_PLOT, 0);
        tick(); n = 3;
        check("t1_first_plot", {VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}, {1'b1, 8'd0, 7'd0, 3'b000});
        while (DONE !== 1'b1 && n < 19300) begin tick(); n++; end
        check("t1_done_cycle", n, 19203);
        check("t1_plot_count", plot_cnt, 19200);
        check("t1_done_flags", {VGA_PLOT, BUSY}, 0);
        tick();
        check("t1_done_pulse", {DONE, BUSY}, 0);

        // Gameplay with car at (10,20), START coincident with the screen change; abort at plot 5000.
        SCREEN = 2'b01; START = 1'b1; CAR_X = 8'd10; CAR_Y = 7'd20;
        base = plot_cnt; done0 = done_cnt;
        tick();
        START = 1'b0;
        n = 0;
        while (plot_cnt - base < 5000 && n < 6000) begin tick(); n++; end
        check("t2_reach_5000", plot_cnt - base, 5000);
        check("t2_sprite_11_20", fb_at(11, 20), 3'b010);
        check("t2_transp_10_20", fb_at(10, 20), 3'b001);
        check("t2_bg_18_20", fb_at(18, 20), 3'b001);
        check("t2_bg_9_20", fb_at(9, 20), 3'b101);
        check("t2_sprite_17_31", fb_at(17, 31), 3'b010);
        SCREEN = 2'b11;
        tick(); n = 1;
        check("t2_squash_e1", {VGA_PLOT, BUSY}, 2'b01);
        tick(); n = 2;
        check("t2_squash_e2", VGA_PLOT, 0);
        check("t2_no_stale", plot_cnt - base, 5000);
        base2 = plot_cnt;
        tick(); n = 3;
        check("t2_restart_pixel", {VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}, {1'b1, 8'd0, 7'd0, 3'b011});
        while (DONE !== 1'b1 && n < 19300) begin tick(); n++; end
        check("t2_done_cycle", n, 19203);
        check("t2_lose_plots", plot_cnt - base2, 19200);
        busy_seen = 1'b0;
        repeat (30) begin tick(); busy_seen = busy_seen | BUSY; end
        check("t2_no_extra_sweep", busy_seen, 0);
        check("t2_single_done", done_cnt - done0, 1);

        // Gameplay with car at the bottom-right corner; START mid-sweep queues a second frame.
        SCREEN = 2'b01; CAR_X = 8'd156; CAR_Y = 7'd115;
        base = plot_cnt;
        tick(); n = 1;
        repeat (1000) begin tick(); n++; end
        START = 1'b1;
        tick(); n++;
        START = 1'b0;
        while (DONE !== 1'b1 && n < 19300) begin tick(); n++; end
        check("t3_done_cycle", n, 19203);
        check("t3_plot_count", plot_cnt - base, 19200);
        mism = 0;
        for (int yy = 0; yy < 120; yy++)
            for (int xx = 0; xx < 160; xx++)
                if (fb_at(xx, yy) !== exp_game(xx, yy, 156, 115)) mism++;
        check("t3_frame_mismatches", mism, 0);
        check("t3_sprite_157_115", fb_at(157, 115), 3'b010);
        check("t3_transp_156_115", fb_at(156, 115), 3'b001);
        check("t3_sprite_159_119", fb_at(159, 119), 3'b010);
        check("t3_no_wrap_1_116", fb_at(1, 116), 3'b101);
        check("t3_no_wrap_2_118", fb_at(2, 118), 3'b001);
        tick();
        check("t3_idle_gap", {BUSY, DONE}, 0);
        tick();
        check("t3_pending_sweep", BUSY, 1);

        // Reset in the middle of the queued sweep, then a title frame from (0,0).
        repeat (3000) tick();
        check("t4_pre_reset", {BUSY, VGA_PLOT}, 2'b11);
        RESETN = 1'b0; SCREEN = 2'b00;
        #1;
        check("t4_async_flags", {VGA_PLOT, BUSY, DONE}, 0);
        check("t4_async_addr", ROM_ADDR, 0);
        tick(); tick();
        RESETN = 1'b1;
        tick();
        check("t4_restart_e1", {BUSY, VGA_PLOT}, 2'b10);
        check("t4_restart_addr", ROM_ADDR, 0);
        tick();
        tick();
        check("t4_first_plot", {VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}, {1'b1, 8'd0, 7'd0, 3'b000});
        tick();
        check("t4_second_plot", {VGA_PLOT, VGA_X, VGA_Y, VGA_COLOUR}, {1'b1, 8'd1, 7'd0, 3'b100});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/frame_painter.md
Name: frame_painter

Overview:
- Raster-paint controller between the game-screen FSM and the 160x120 VGA adapter.
- Paints exactly one frame into the adapter's frame buffer on each trigger:
  - a screen change,
  - an explicit redraw request, or
  - reset release.
- Walks every pixel, issues screen-ROM and car-sprite-ROM addresses, and compensates for ROM read latency.
- On the gameplay screen, composites the car sprite over the background, then drives the adapter's x/y/colour/plot port.

Parameters:
- H_RES, 160, pixel columns per frame
- V_RES, 120, pixel rows per frame
- ROM_LATENCY, 1, cycles from address presented to ROM data valid (all ROMs identical)
- SPRITE_W, 8, car sprite width in pixels
- SPRITE_H, 12, car sprite height in pixels
- TRANSPARENT, 3'b101, sprite colour treated as see-through

Ports:
- CLOCK  in  1  system clock (CLOCK_50)
- RESETN  in  1  reset, asynchronous, active-low
- SCREEN  in  2  screen select from FSM: 00 title, 01 gameplay, 10 win, 11 lose
- START  in  1  redraw request pulse (e.g. car moved)
- CAR_X  in  8  car sprite top-left column
- CAR_Y  in  7  car sprite top-left row
- BG_COLOUR  in  3  muxed screen-ROM data for ROM_ADDR
- SPR_COLOUR  in  3  sprite-ROM data for SPR_ADDR
- ROM_ADDR  out  15  {y[6:0], x[7:0]} to all screen ROMs
- SPR_ADDR  out  7  sprite-ROM address
- VGA_X  out  8  plot column
- VGA_Y  out  7  plot row
- VGA_COLOUR  out  3  plot colour
- VGA_PLOT  out  1  write strobe to adapter
- BUSY  out  1  high while painting (SWEEP or FLUSH)
- DONE  out  1  one-cycle pulse after the last pixel is plotted

Behaviour:
Reset values:
- All outputs 0.
- State IDLE; screen register 00.
- Pending flag = 1, so one frame of the title screen paints after reset release.

States:
- IDLE:
  - Trigger = pending | START | (SCREEN != screen register).
  - On trigger: latch SCREEN, CAR_X and CAR_Y; clear x,y to 0; clear pending; go to SWEEP.
  - Simultaneous START and screen change produce a single sweep.
- SWEEP:
  - Each cycle drives ROM_ADDR/SPR_ADDR for (x,y), then advances x.
  - x wraps at H_RES-1 and increments y.
  - At (H_RES-1, V_RES-1), go to FLUSH.
- FLUSH:
  - Waits ROM_LATENCY cycles for in-flight pixels to drain.
  - Then go to DONE_ST.
- DONE_ST: DONE=1 for one cycle, BUSY=0, then IDLE.

Pipeline and timing:
- A ROM_LATENCY-deep shift register carries {valid, x, y, in_sprite}.
- The output stage is registered.
- Pixel p's VGA_PLOT/VGA_X/VGA_Y/VGA_COLOUR are valid exactly ROM_LATENCY+1 cycles after its ROM_ADDR is driven.
- Trigger edge to DONE pulse = H_RES*V_RES + ROM_LATENCY + 2 cycles, i.e. 19203 at defaults.
- VGA_PLOT is high for exactly H_RES*V_RES cycles per frame.

Sprite compositing:
- dx = x - CAR_X and dy = y - CAR_Y, computed in 8 bits unsigned.
- in_sprite = (latched SCREEN == 01) & dx < SPRITE_W & dy < SPRITE_H.
- SPR_ADDR = dy*SPRITE_W + dx.
- Output colour = SPR_COLOUR if in_sprite & SPR_COLOUR != TRANSPARENT; otherwise BG_COLOUR.
- Sprite parts past column 159 or row 119 are clipped, never wrapped to column/row 0.
- CAR_X/CAR_Y changes mid-sweep are ignored until the next trigger, so there is no tearing.

Interruptions:
- SCREEN change during SWEEP/FLUSH:
  - Abort the sweep.
  - Squash all pipeline valid bits; no stale pixel is plotted.
  - Latch the new SCREEN and restart SWEEP at (0,0) on the next cycle. No DONE pulse for the aborted frame.
- START during SWEEP/FLUSH/DONE_ST sets pending and is serviced from IDLE.
- RESETN low at any time: immediate return to reset values; VGA_PLOT drops asynchronously.

Decomposition:
- Package frame_pkg:
  - H_RES/V_RES defaults.
  - Screen encodings SCR_TITLE/SCR_GAME/SCR_WIN/SCR_LOSE.
  - State enum IDLE/SWEEP/FLUSH/DONE_ST.
  - COLOUR_W=3.
- Sub-module raster_xy: x/y counter with clear, enable, wrap, and a last-pixel flag. Used by frame_painter; reusable for other full-frame blanking.

Test Plan:
- Release reset with SCREEN=00 and ROM_LATENCY=1 -> sweep starts without START; the first plot has VGA_X=0/VGA_Y=0 two cycles after ROM_ADDR=0; exactly 19200 plots; DONE at cycle 19203; BUSY low afterwards.
- SCREEN=01, CAR_X=10, CAR_Y=20, sprite model returns 3'b010 except TRANSPARENT at dx=0 -> pixel (11,20) plots 010; (10,20) and (18,20) plot BG_COLOUR.
- CAR_X=156, CAR_Y=115 -> sprite pixels are plotted only at x 156..159 and y 115..119; no plot at x<8 in rows 115..119 carries sprite colour.
- At the 5000th plot, change SCREEN 01->11 -> no further 01-frame pixels are plotted; the next plot is (0,0) with lose data; exactly one DONE, after the full 19200-pixel lose frame.
- START pulse during SWEEP -> after DONE, one IDLE cycle, then a second full sweep; START coincident with a SCREEN change in IDLE -> only one sweep.
- Assert RESETN low mid-sweep -> VGA_PLOT/BUSY/DONE go 0 immediately; after release, a title-screen sweep starts from (0,0).
